// File: rtl/addr_mux2_4_pkg.sv
// ----------------------------------------------------------------------------
// addr_pkg
// Shared definitions for the two-source address multiplexer slice.
//   ADDR_W : default address width
//   addr_t : address word type of ADDR_W bits
//   SEL_A  : select code that picks source A (address_1)
//   SEL_B  : select code that picks source B (address_2)
// ----------------------------------------------------------------------------
package addr_pkg;

    localparam int ADDR_W = 4;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : addr_pkg

// File: rtl/addr_mux2_4_if.sv
// ----------------------------------------------------------------------------
// addr_mux2_4_if
// Bundles the address sources, the select/enable controls and the three
// results of the address multiplexer.
//   address_1   : source A, chosen when select = SEL_A
//   address_2   : source B, chosen when select = SEL_B
//   select      : source select
//   en          : load enable for the registered copies
//   address_out : combinational mux result
//   address_q   : registered mux result
//   select_q    : registered select, identifies the source of address_q
// Modports: master drives sources/controls, slave is the multiplexer.
// ----------------------------------------------------------------------------
interface addr_mux2_4_if
    import addr_pkg::*;
#(
    parameter int WIDTH = ADDR_W
);

    logic [WIDTH-1:0] address_1;
    logic [WIDTH-1:0] address_2;
    logic             select;
    logic             en;
    logic [WIDTH-1:0] address_out;
    logic [WIDTH-1:0] address_q;
    logic             select_q;

    modport master (
        output address_1,
        output address_2,
        output select,
        output en,
        input  address_out,
        input  address_q,
        input  select_q
    );

    modport slave (
        input  address_1,
        input  address_2,
        input  select,
        input  en,
        output address_out,
        output address_q,
        output select_q
    );

endinterface : addr_mux2_4_if

// File: rtl/addr_mux2_4_reg.sv
// ----------------------------------------------------------------------------
// addr_reg
// WIDTH-bit register with asynchronous active-high reset and load enable.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, forces q to RESET_VAL
//   en  : 1 = capture d on the clock edge, 0 = hold
//   d   : data in
//   q   : registered data out
// ----------------------------------------------------------------------------
module addr_reg #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset is checked first so an edge coincident with reset never loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : addr_reg

// File: rtl/addr_mux2_4.sv
// ----------------------------------------------------------------------------
// addr_mux2_4
// 2-to-1 address multiplexer, e.g. program counter vs. instruction operand
// feeding the memory address register. Gives a zero-latency combinational
// result and a registered copy together with the select that produced it.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears address_q / select_q only)
//   bus : addr_mux2_4_if slave modport
//         address_1, address_2, select, en  -> in
//         address_out, address_q, select_q  -> out
// ----------------------------------------------------------------------------
module addr_mux2_4
    import addr_pkg::*;
#(
    parameter int               WIDTH     = ADDR_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    addr_mux2_4_if.slave bus
);

    logic [WIDTH-1:0] mux_out;

    // An unknown select is left to propagate as X rather than being resolved.
    assign mux_out         = (bus.select == SEL_B) ? bus.address_2 : bus.address_1;
    assign bus.address_out = mux_out;

    addr_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_address_reg (
        .clk (clk),
        .rst (rst),
        .en  (bus.en),
        .d   (mux_out),
        .q   (bus.address_q)
    );

    // Resets to SEL_A so a cleared address_q reads as coming from source A.
    addr_reg #(
        .WIDTH     (1),
        .RESET_VAL (SEL_A)
    ) u_select_reg (
        .clk (clk),
        .rst (rst),
        .en  (bus.en),
        .d   (bus.select),
        .q   (bus.select_q)
    );

endmodule : addr_mux2_4

// File: tb/tb_addr_mux2_4.sv
// ----------------------------------------------------------------------------
// tb_addr_mux2_4
// Directed testbench for addr_mux2_4: combinational selection, registered
// load/hold, asynchronous reset and reset coincident with a clock edge.
// ----------------------------------------------------------------------------
module tb_addr_mux2_4;

    import addr_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    addr_mux2_4_if #(.WIDTH(ADDR_W)) bus ();

    addr_mux2_4 #(
        .WIDTH     (ADDR_W),
        .RESET_VAL (4'b0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive all multiplexer inputs, then let combinational logic settle.
    task automatic applyStimulus(input addr_t a1, input addr_t a2,
                                 input logic sel, input logic load);
        bus.address_1 = a1;
        bus.address_2 = a2;
        bus.select    = sel;
        bus.en        = load;
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input addr_t observed,
                               input addr_t expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Reset state
        checkOutput("reset_address_q", bus.address_q, 4'b0000);
        checkOutput("reset_select_q", {3'b000, bus.select_q}, 4'b0000);

        // Combinational selection, while still in reset
        applyStimulus(4'b0001, 4'b1111, 1'b1, 1'b0);
        checkOutput("comb_sel_b", bus.address_out, 4'b1111);
        applyStimulus(4'b0010, 4'b1110, 1'b0, 1'b0);
        checkOutput("comb_sel_a", bus.address_out, 4'b0010);

        // Twelve steps: address_1 counts up, address_2 counts down (wrapping
        // 0000 -> 1111 on step 1), select toggles starting at 1.
        for (int k = 1; k <= 12; k++) begin
            addr_t a1;
            addr_t a2;
            logic  sel;
            a1  = addr_t'(k);
            a2  = addr_t'(16 - k);
            sel = (k % 2) == 1;
            applyStimulus(a1, a2, sel, 1'b0);
            checkOutput($sformatf("walk_step%0d", k), bus.address_out, sel ? a2 : a1);
        end
        checkOutput("walk_final", bus.address_out, 4'b1100);

        // Release reset and load source B
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b0011, 4'b1010, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("load_address_q", bus.address_q, 4'b1010);
        checkOutput("load_select_q", {3'b000, bus.select_q}, 4'b0001);

        // Hold with en=0 for three edges while address_out follows inputs
        applyStimulus(4'b0101, 4'b0101, 1'b0, 1'b0);
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_address_q_%0d", e), bus.address_q, 4'b1010);
            checkOutput($sformatf("hold_select_q_%0d", e), {3'b000, bus.select_q}, 4'b0001);
            checkOutput($sformatf("hold_address_out_%0d", e), bus.address_out, 4'b0101);
        end

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_address_q", bus.address_q, 4'b0000);
        checkOutput("async_rst_select_q", {3'b000, bus.select_q}, 4'b0000);
        checkOutput("async_rst_address_out", bus.address_out, 4'b0101);

        // Reset held across an enabled edge: no load
        applyStimulus(4'b0111, 4'b1001, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("rst_hold_address_q", bus.address_q, 4'b0000);

        // Release with en=1: first edge loads
        rst = 1'b0;
        @(negedge clk);
        checkOutput("release_address_q", bus.address_q, 4'b0111);
        checkOutput("release_select_q", {3'b000, bus.select_q}, 4'b0000);

        // Reset coincident with a clock edge while address_out=1111
        applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1);
        checkOutput("pre_coincident_out", bus.address_out, 4'b1111);
        @(posedge clk);
        rst = 1'b1;
        #1;
        checkOutput("coincident_address_q", bus.address_q, 4'b0000);
        checkOutput("coincident_select_q", {3'b000, bus.select_q}, 4'b0000);

        // Release and load the pending value
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("final_address_q", bus.address_q, 4'b1111);
        checkOutput("final_select_q", {3'b000, bus.select_q}, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_addr_mux2_4
